// File: rtl/fifo_rd_stream_if.sv
// Downstream valid/ready stream carrying data plus a burst-end tag.
// The drain engine drives it through the master modport; the consumer uses slave.
interface fifo_rd_stream_if #(
  parameter int DSIZE = 8
);
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine for the async FIFO (rclk domain).
// Pops first-word-fall-through FIFO words into a 2-entry output buffer and
// presents them as a valid/ready stream tagged with a burst-end flag.
// Optional macro FIFO_RD_STATS_EN adds the rd_count/stall_count counters.
module fifo_rd_stream #(
  parameter int DSIZE     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             flush,
`ifdef FIFO_RD_STATS_EN
  output logic [15:0]      rd_count,
  output logic [15:0]      stall_count,
`endif
  fifo_rd_stream_if.master m
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [1:0]    OCC_EMPTY = 2'd0;
  localparam logic [1:0]    OCC_ONE   = 2'd1;
  localparam logic [1:0]    OCC_TWO   = 2'd2;
  localparam logic [BW-1:0] BCNT_LAST = BW'(BURST_LEN - 1);

  logic [1:0]       occ_r, occ_n_s;
  logic             valid_r, valid_n_s;
  logic [DSIZE-1:0] head_data_r, head_data_n_s;
  logic             head_last_r, head_last_n_s;
  logic [DSIZE-1:0] tail_data_r, tail_data_n_s;
  logic             tail_last_r, tail_last_n_s;
  logic [BW-1:0]    bcnt_r, bcnt_n_s;
  logic             pop_s, take_s, tag_s;

  // Pop depends only on rempty/flush and registered state; reset blocks popping.
  assign pop_s  = rrst_n && !rempty && (occ_r != OCC_TWO) && !flush;
  assign rinc   = pop_s;
  assign take_s = valid_r && m.m_ready;
  assign tag_s  = (bcnt_r == BCNT_LAST);

  assign m.m_data  = head_data_r;
  assign m.m_last  = head_last_r;
  assign m.m_valid = valid_r;

  // Next-state for the buffer occupancy, the two entries and the burst counter.
  always_comb begin
    occ_n_s       = occ_r;
    head_data_n_s = head_data_r;
    head_last_n_s = head_last_r;
    tail_data_n_s = tail_data_r;
    tail_last_n_s = tail_last_r;
    bcnt_n_s      = bcnt_r;
    if (flush) begin
      occ_n_s  = OCC_EMPTY;
      bcnt_n_s = {BW{1'b0}};
    end else begin
      case (occ_r)
        OCC_EMPTY: begin
          if (pop_s) begin
            occ_n_s       = OCC_ONE;
            head_data_n_s = rdata;
            head_last_n_s = tag_s;
          end else begin
            occ_n_s = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (pop_s && !take_s) begin
            occ_n_s       = OCC_TWO;
            tail_data_n_s = rdata;
            tail_last_n_s = tag_s;
          end else if (pop_s && take_s) begin
            occ_n_s       = OCC_ONE;
            head_data_n_s = rdata;
            head_last_n_s = tag_s;
          end else if (take_s) begin
            occ_n_s = OCC_EMPTY;
          end else begin
            occ_n_s = OCC_ONE;
          end
        end
        OCC_TWO: begin
          if (take_s) begin
            occ_n_s       = OCC_ONE;
            head_data_n_s = tail_data_r;
            head_last_n_s = tail_last_r;
          end else begin
            occ_n_s = OCC_TWO;
          end
        end
        default: begin
          occ_n_s = OCC_EMPTY;
        end
      endcase
      if (pop_s) begin
        bcnt_n_s = tag_s ? {BW{1'b0}} : (bcnt_r + BW'(1));
      end else begin
        bcnt_n_s = bcnt_r;
      end
    end
    valid_n_s = (occ_n_s != OCC_EMPTY);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      occ_r       <= OCC_EMPTY;
      valid_r     <= 1'b0;
      head_data_r <= {DSIZE{1'b0}};
      head_last_r <= 1'b0;
      tail_data_r <= {DSIZE{1'b0}};
      tail_last_r <= 1'b0;
      bcnt_r      <= {BW{1'b0}};
    end else begin
      occ_r       <= occ_n_s;
      valid_r     <= valid_n_s;
      head_data_r <= head_data_n_s;
      head_last_r <= head_last_n_s;
      tail_data_r <= tail_data_n_s;
      tail_last_r <= tail_last_n_s;
      bcnt_r      <= bcnt_n_s;
    end
  end

`ifdef FIFO_RD_STATS_EN
  // Delivered-word counter (wrapping) and backpressure counter (saturating).
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rd_count    <= 16'd0;
      stall_count <= 16'd0;
    end else if (flush) begin
      rd_count    <= 16'd0;
      stall_count <= 16'd0;
    end else begin
      if (take_s) begin
        rd_count <= rd_count + 16'd1;
      end else begin
        rd_count <= rd_count;
      end
      if (valid_r && !m.m_ready && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end else begin
        stall_count <= stall_count;
      end
    end
  end
`endif

endmodule
